// File: rtl/fpu_issue.sv
// fpu_issue: in-order operand queue and scoreboard feeding a single FPU issue port.
// Optional build macro FPU_ISSUE_STATS_EN adds issue_cnt / stall_cnt counters.
module fpu_issue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_ds,
  input  logic [5:0]  in_dt,
  input  logic [31:0] in_ds_val,
  input  logic [31:0] in_dt_val,
  input  logic [5:0]  in_dd,
  input  logic [15:0] in_imm,
  input  logic [3:0]  in_ctrl,
  input  logic [6:0]  is_busy,
  input  logic [5:0]  fpu_addr,
  input  logic [31:0] fpu_dd_val,
  output logic [31:0] ds_val,
  output logic [31:0] dt_val,
  output logic [5:0]  dd,
  output logic [15:0] imm,
  output logic [3:0]  ctrl
`ifdef FPU_ISSUE_STATS_EN
  ,
  output logic [31:0] issue_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] ds_val;
    logic [31:0] dt_val;
    logic [5:0]  dd;
    logic [15:0] imm;
    logic [3:0]  ctrl;
    logic [5:0]  ds;
    logic [5:0]  dt;
    logic        ds_wait;
    logic        dt_wait;
  } entry_t;

  entry_t           q     [DEPTH];
  entry_t           q_nxt [DEPTH];
  entry_t           new_e;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [63:0]      pending;
  logic [63:0]      pending_nxt;
  logic [DEPTH-1:0] slot_valid;
  logic [7:0]       busy_ext;
  logic             head_valid;
  logic             issue;
  logic             enq;
  logic             ds_older;
  logic             dt_older;
  logic [32:0]      ds_res;
  logic [32:0]      dt_res;

  // Resolve one incoming operand into {wait, value}.
  function automatic logic [32:0] resolve_src(
    input logic [5:0]  src,
    input logic [31:0] rf_val,
    input logic        older_dd,
    input logic        pend,
    input logic [5:0]  wb_addr,
    input logic [31:0] wb_val
  );
    logic [32:0] r;
    r = {1'b0, rf_val};
    if (src == 6'd0) begin
      r = {1'b0, rf_val};
    end else if (older_dd) begin
      r = {1'b1, rf_val};
    end else if (wb_addr == src) begin
      r = {1'b0, wb_val};
    end else if (pend) begin
      r = {1'b1, rf_val};
    end
    return r;
  endfunction

  // Occupancy mask, head eligibility and enqueue decision.
  always_comb begin
    slot_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_valid[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count;
    end
    busy_ext   = {1'b0, is_busy};
    head_valid = (count != CNT_W'(0));
    issue      = head_valid && !q[rd_ptr].ds_wait && !q[rd_ptr].dt_wait &&
                 !busy_ext[q[rd_ptr].ctrl[2:0]] &&
                 ((q[rd_ptr].dd == 6'd0) || !pending[q[rd_ptr].dd]);
    enq        = in_valid && in_ready && (in_ctrl != 4'd0);
  end

  // Build the entry being enqueued, including hazard detection and bypass.
  always_comb begin
    ds_older = 1'b0;
    dt_older = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && (q[i].dd == in_ds)) ds_older = 1'b1;
      if (slot_valid[i] && (q[i].dd == in_dt)) dt_older = 1'b1;
    end
    ds_res = resolve_src(in_ds, in_ds_val, ds_older, pending[in_ds], fpu_addr, fpu_dd_val);
    dt_res = resolve_src(in_dt, in_dt_val, dt_older, pending[in_dt], fpu_addr, fpu_dd_val);
    new_e         = '0;
    new_e.ds_val  = ds_res[31:0];
    new_e.ds_wait = ds_res[32];
    new_e.dt_val  = dt_res[31:0];
    new_e.dt_wait = dt_res[32];
    new_e.dd      = in_dd;
    new_e.imm     = in_imm;
    new_e.ctrl    = in_ctrl;
    new_e.ds      = in_ds;
    new_e.dt      = in_dt;
  end

  // Writeback wakeup of waiting operands, then insertion at the tail.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      q_nxt[i] = q[i];
      if (slot_valid[i] && q[i].ds_wait && (fpu_addr != 6'd0) && (q[i].ds == fpu_addr)) begin
        q_nxt[i].ds_val  = fpu_dd_val;
        q_nxt[i].ds_wait = 1'b0;
      end
      if (slot_valid[i] && q[i].dt_wait && (fpu_addr != 6'd0) && (q[i].dt == fpu_addr)) begin
        q_nxt[i].dt_val  = fpu_dd_val;
        q_nxt[i].dt_wait = 1'b0;
      end
    end
    if (enq) q_nxt[wr_ptr] = new_e;
  end

  // Scoreboard and occupancy next state; a set wins over a same-cycle clear.
  always_comb begin
    pending_nxt = pending;
    if (fpu_addr != 6'd0) pending_nxt[fpu_addr] = 1'b0;
    if (issue && (q[rd_ptr].dd != 6'd0)) pending_nxt[q[rd_ptr].dd] = 1'b1;
    pending_nxt[0] = 1'b0;
    count_nxt = count + CNT_W'(enq) - CNT_W'(issue);
  end

  // Queue payload storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    q <= q_nxt;
  end

  // Queue control, scoreboard and ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      in_ready <= 1'b1;
    end else begin
      if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq)   wr_ptr <= wr_ptr + PTR_W'(1);
      count    <= count_nxt;
      pending  <= pending_nxt;
      in_ready <= (count_nxt < CNT_W'(DEPTH));
    end
  end

  // Registered issue bus; ctrl drops to a bubble when nothing issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      ds_val <= '0;
      dt_val <= '0;
      dd     <= '0;
      imm    <= '0;
      ctrl   <= '0;
    end else if (issue) begin
      ds_val <= q[rd_ptr].ds_val;
      dt_val <= q[rd_ptr].dt_val;
      dd     <= q[rd_ptr].dd;
      imm    <= q[rd_ptr].imm;
      ctrl   <= q[rd_ptr].ctrl;
    end else begin
      ctrl   <= 4'd0;
    end
  end

`ifdef FPU_ISSUE_STATS_EN
  // Issue and head-stall counters, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue)               issue_cnt <= issue_cnt + 32'd1;
      if (head_valid && !issue) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issue.sv
// Self-checking bench for fpu_issue: scoreboard of expected issue-bus beats plus per-scenario checks.
module tb_fpu_issue;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] dsv;
    logic [31:0] dtv;
    logic [5:0]  dd;
    logic [15:0] imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_ds;
  logic [5:0]  in_dt;
  logic [31:0] in_ds_val;
  logic [31:0] in_dt_val;
  logic [5:0]  in_dd;
  logic [15:0] in_imm;
  logic [3:0]  in_ctrl;
  logic [6:0]  is_busy;
  logic [5:0]  fpu_addr;
  logic [31:0] fpu_dd_val;
  logic [31:0] ds_val;
  logic [31:0] dt_val;
  logic [5:0]  dd;
  logic [15:0] imm;
  logic [3:0]  ctrl;

  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  exp_t sb [$];

  fpu_issue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ds(in_ds), .in_dt(in_dt), .in_ds_val(in_ds_val), .in_dt_val(in_dt_val),
    .in_dd(in_dd), .in_imm(in_imm), .in_ctrl(in_ctrl), .is_busy(is_busy),
    .fpu_addr(fpu_addr), .fpu_dd_val(fpu_dd_val),
    .ds_val(ds_val), .dt_val(dt_val), .dd(dd), .imm(imm), .ctrl(ctrl)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic offer(input logic [3:0] c, input logic [5:0] s, input logic [5:0] t,
                       input logic [31:0] sv, input logic [31:0] tv,
                       input logic [5:0] d, input logic [15:0] im);
    in_valid = 1'b1; in_ctrl = c; in_ds = s; in_dt = t;
    in_ds_val = sv; in_dt_val = tv; in_dd = d; in_imm = im;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_ctrl = '0; in_ds = '0; in_dt = '0;
    in_ds_val = '0; in_dt_val = '0; in_dd = '0; in_imm = '0;
  endtask

  // Pops one expected beat for every non-bubble cycle on the issue bus.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && (ctrl != 4'd0)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got ctrl=%0d ds=%h, none expected", ctrl, ds_val);
        end else begin
          e = sb.pop_front();
          if ({ctrl, ds_val, dt_val, dd, imm} !== e) begin
            errors++;
            $display("FAIL sb_issue: got ctrl=%0d ds=%h dt=%h dd=%0d imm=%h want ctrl=%0d ds=%h dt=%h dd=%0d imm=%h",
                     ctrl, ds_val, dt_val, dd, imm, e.ctrl, e.dsv, e.dtv, e.dd, e.imm);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; is_busy = '0; fpu_addr = '0; fpu_dd_val = '0;
    idle();
    tick(); tick();
    checks++;
    if ({ctrl, ds_val, dt_val, dd, imm} !== 90'd0) begin
      errors++;
      $display("FAIL reset_bus: got ctrl=%0d ds=%h dt=%h dd=%0d imm=%h want all 0", ctrl, ds_val, dt_val, dd, imm);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    offer(4'd3, 6'd0, 6'd0, 32'd5, 32'd7, 6'd4, 16'h1234);
    sb.push_back({4'd3, 32'd5, 32'd7, 6'd4, 16'h1234});
    tick(); idle();
    checks++;
    if (ctrl !== 4'd0) begin errors++; $display("FAIL single_early: got ctrl=%0d want 0", ctrl); end
    tick();
    checks++;
    if (ctrl !== 4'd3) begin errors++; $display("FAIL single_latency: got ctrl=%0d want 3", ctrl); end
    checks++;
    if (dut.pending[4] !== 1'b1) begin errors++; $display("FAIL single_pending: got %b want 1", dut.pending[4]); end
  endtask

  task automatic test_raw();
    offer(4'd5, 6'd4, 6'd0, 32'hDEAD, 32'h77, 6'd0, 16'd1);
    sb.push_back({4'd5, 32'h12, 32'h77, 6'd0, 16'd1});
    tick(); idle();
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (ctrl !== 4'd0) begin errors++; $display("FAIL raw_wait%0d: got ctrl=%0d want 0", k, ctrl); end
    end
    fpu_addr = 6'd4; fpu_dd_val = 32'h12;
    tick();
    fpu_addr = 6'd0; fpu_dd_val = '0;
    checks++;
    if (ctrl !== 4'd0) begin errors++; $display("FAIL raw_wb_cycle: got ctrl=%0d want 0", ctrl); end
    tick();
    checks++;
    if (ctrl !== 4'd5) begin errors++; $display("FAIL raw_issue: got ctrl=%0d want 5", ctrl); end
    checks++;
    if (dut.pending[4] !== 1'b0) begin errors++; $display("FAIL raw_clear: got %b want 0", dut.pending[4]); end
  endtask

  task automatic test_bypass();
    offer(4'd2, 6'd0, 6'd0, 32'h1, 32'h2, 6'd9, 16'd2);
    sb.push_back({4'd2, 32'h1, 32'h2, 6'd9, 16'd2});
    tick(); idle();
    tick();
    offer(4'd6, 6'd9, 6'd0, 32'h0, 32'h3, 6'd0, 16'd7);
    fpu_addr = 6'd9; fpu_dd_val = 32'hAB;
    sb.push_back({4'd6, 32'hAB, 32'h3, 6'd0, 16'd7});
    tick(); idle();
    fpu_addr = 6'd0; fpu_dd_val = '0;
    checks++;
    if (ctrl !== 4'd0) begin errors++; $display("FAIL bypass_early: got ctrl=%0d want 0", ctrl); end
    tick();
    checks++;
    if (ctrl !== 4'd6) begin errors++; $display("FAIL bypass_issue: got ctrl=%0d want 6", ctrl); end
  endtask

  task automatic test_older_dep();
    is_busy = 7'b0000010;
    offer(4'd1, 6'd0, 6'd0, 32'h1, 32'h2, 6'd10, 16'd2);
    sb.push_back({4'd1, 32'h1, 32'h2, 6'd10, 16'd2});
    tick();
    offer(4'd7, 6'd10, 6'd0, 32'hBAD, 32'h4, 6'd0, 16'd3);
    fpu_addr = 6'd10; fpu_dd_val = 32'h99;
    sb.push_back({4'd7, 32'h55, 32'h4, 6'd0, 16'd3});
    tick(); idle();
    fpu_addr = 6'd0; fpu_dd_val = '0;
    checks++;
    if (ctrl !== 4'd0) begin errors++; $display("FAIL dep_busy0: got ctrl=%0d want 0", ctrl); end
    tick();
    checks++;
    if (ctrl !== 4'd0) begin errors++; $display("FAIL dep_busy1: got ctrl=%0d want 0", ctrl); end
    is_busy = '0;
    tick();
    checks++;
    if (ctrl !== 4'd1) begin errors++; $display("FAIL dep_producer: got ctrl=%0d want 1", ctrl); end
    fpu_addr = 6'd10; fpu_dd_val = 32'h55;
    tick();
    fpu_addr = 6'd0; fpu_dd_val = '0;
    checks++;
    if (ctrl !== 4'd0) begin errors++; $display("FAIL dep_wake: got ctrl=%0d want 0", ctrl); end
    tick();
    checks++;
    if (ctrl !== 4'd7) begin errors++; $display("FAIL dep_consumer: got ctrl=%0d want 7", ctrl); end
  endtask

  task automatic test_busy_full();
    is_busy = 7'b0001000;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== (i < 4)) begin
        errors++; $display("FAIL full_ready%0d: got %b want %b", i, in_ready, (i < 4));
      end
      offer(4'd3, 6'd0, 6'd0, 32'h100 + 32'(i), 32'h200 + 32'(i), 6'd0, 16'(i));
      if (i < 4) sb.push_back({4'd3, 32'h100 + 32'(i), 32'h200 + 32'(i), 6'd0, 16'(i)});
      tick();
    end
    checks++;
    if (ctrl !== 4'd0) begin errors++; $display("FAIL full_bubble: got ctrl=%0d want 0", ctrl); end
    is_busy = '0;
    sb.push_back({4'd3, 32'h104, 32'h204, 6'd0, 16'd4});
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_issue: got %b want 0", in_ready); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (ctrl !== 4'd3) begin errors++; $display("FAIL drain%0d: got ctrl=%0d want 3", k, ctrl); end
      if (k == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready: got %b want 1", in_ready); end
      end
      if (k == 1) idle();
    end
    tick();
    checks++;
    if (ctrl !== 4'd0) begin errors++; $display("FAIL drain_done: got ctrl=%0d want 0", ctrl); end
  endtask

  task automatic test_reset_mid();
    offer(4'd2, 6'd0, 6'd0, 32'h21, 32'h22, 6'd12, 16'd5);
    sb.push_back({4'd2, 32'h21, 32'h22, 6'd12, 16'd5});
    tick(); idle();
    tick();
    checks++;
    if (dut.pending[12] !== 1'b1) begin errors++; $display("FAIL mid_pending_set: got %b want 1", dut.pending[12]); end
    is_busy = 7'b0001000;
    for (int i = 0; i < 4; i++) begin
      offer(4'd3, 6'd12, 6'd0, 32'h300 + 32'(i), 32'h0, 6'd0, 16'd0);
      tick();
    end
    idle();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got %b want 0", in_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ctrl, ds_val, dt_val, dd, imm} !== 90'd0) begin
      errors++;
      $display("FAIL mid_bus: got ctrl=%0d ds=%h dt=%h dd=%0d imm=%h want all 0", ctrl, ds_val, dt_val, dd, imm);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", in_ready); end
    checks++;
    if (dut.pending !== 64'd0) begin errors++; $display("FAIL mid_pending: got %h want 0", dut.pending); end
    fpu_addr = 6'd4; fpu_dd_val = 32'h1;
    tick();
    fpu_addr = 6'd0; fpu_dd_val = '0;
    checks++;
    if (dut.pending !== 64'd0) begin errors++; $display("FAIL mid_wb_pending: got %h want 0", dut.pending); end
    is_busy = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ctrl !== 4'd0) begin errors++; $display("FAIL mid_discard%0d: got ctrl=%0d want 0", k, ctrl); end
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_single();
    test_raw();
    test_bypass();
    test_older_dep();
    test_busy_full();
    test_reset_mid();
    tick(); tick();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending beats want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue.md
FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 Parameter DEPTH, default 4, is the operand queue depth in entries (power of two, minimum 2).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 in_valid  in  1  decode offers an instruction this cycle.
REQ-005 in_ready  out  1  queue can accept; high iff occupancy < DEPTH.
REQ-006 in_ds, in_dt  in  6 each  source register numbers; 0 means no source.
REQ-007 in_ds_val, in_dt_val  in  32 each  register-file values read at decode.
REQ-008 in_dd  in  6  destination register; 0 means no writeback.
REQ-009 in_imm  in  16  immediate, passed through unchanged.
REQ-010 in_ctrl  in  4  FPU op code; 4'b0000 is NOP.
REQ-011 is_busy  in  7  per-class FPU busy; class = ctrl[2:0]; class 7 is never busy.
REQ-012 fpu_addr, fpu_dd_val  in  6, 32  FPU writeback; fpu_addr 0 means no writeback.
REQ-013 ds_val, dt_val, dd, imm, ctrl  out  32/32/6/16/4  registered issue bus to the FPU; ctrl 0 is a bubble.

Function
REQ-014 An enqueue occurs when in_valid && in_ready && in_ctrl != 0; in_ctrl == 0 is accepted and discarded.
REQ-015 The queue is in-order FIFO; each entry holds ds_val, dt_val, dd, imm, ctrl, ds, dt, ds_wait, dt_wait.
REQ-016 A 63-bit scoreboard pending[1..63] is kept; r0 is never pending.
REQ-017 Pending set: issue of a non-NOP with dd != 0 sets pending[dd].
REQ-018 Pending clear: fpu_addr != 0 clears pending[fpu_addr].
REQ-019 Set and clear of the same register in one cycle leaves it set.
REQ-020 Enqueue wait: operand src != 0 gets wait=1 if pending[src] or any older queued entry (including one issuing this cycle) has dd == src.
REQ-021 Same-cycle bypass: if fpu_addr == src != 0 and no older queued entry has dd == src, store fpu_dd_val and set wait=0.
REQ-022 Every cycle, each queued operand with wait=1 and src == fpu_addr != 0 captures fpu_dd_val and clears wait.
REQ-023 Head issues when valid && !ds_wait && !dt_wait && !is_busy[ctrl[2:0]] (class 7 exempt) && (dd == 0 || !pending[dd]).
REQ-024 Issue latency: head fields appear on the output bus at the next rising edge; at most one issue per cycle.
REQ-025 Output ctrl is 0 in any cycle following a non-issue cycle; ds_val/dt_val/dd/imm hold their last values.
REQ-026 Enqueue and issue in the same cycle leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-027 When full, in_ready is 0 even if the head issues that cycle.
REQ-028 Minimum latency, empty queue and no hazards: in_valid edge N, bus valid edge N+1.

Reset
REQ-029 While rst=1 at a clock edge: queue empty, all pending bits 0, all outputs 0, in_ready 1 on the next cycle.
REQ-030 Reset mid-operation discards queued entries and scoreboard state; writebacks arriving after reset do not create pending bits.

Configuration
REQ-031 Macro FPU_ISSUE_STATS_EN adds outputs issue_cnt[31:0] (increments per issue) and stall_cnt[31:0] (increments per cycle with a valid but ineligible head).
REQ-032 With FPU_ISSUE_STATS_EN, both counters reset to 0 and wrap at 2^32.
REQ-033 Without FPU_ISSUE_STATS_EN, those ports and counters do not exist and behaviour is otherwise identical.

Verification
REQ-034 Reset, then enqueue ctrl=3, ds_val=5, dt_val=7, dd=4 -> next edge ctrl=3, ds_val=5, dt_val=7, dd=4, pending[4]=1.
REQ-035 Issue dd=4, enqueue ds=4; after 3 cycles fpu_addr=4, fpu_dd_val=0x12 -> RAW instruction issues the following edge with ds_val=0x12.
REQ-036 Enqueue ds=9 with pending[9]=1 in the same cycle as fpu_addr=9, fpu_dd_val=0xAB -> entry has ds_wait=0; issue next edge with ds_val=0xAB.
REQ-037 is_busy[3]=1, enqueue 5 ctrl=3 ops -> in_ready=0 after 4 enqueues, ctrl=0 on the bus; drop busy -> one issue per cycle, in order.
REQ-038 Fill the queue, assert rst for one cycle -> all outputs 0, in_ready=1, and a later fpu_addr=4 leaves pending empty.
